uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the core's data-side bus, downstream of the core's store/load ports.
- Stores from the execute stage push bytes into a TX FIFO.
- A bit-serial FSM shifts the bytes out LSB-first on a single TX line.
- Loads issued by the decode stage return status and config registers one cycle later, matching the core's read timing.
- Returns 0 for addresses outside its window, so its read data can be OR-combined with RAM read data.

Parameters:
BASE_ADDR, 32'h1000_0000, window base; 16-byte window, match when addr[31:4]==BASE_ADDR[31:4]
FIFO_DEPTH, 8, TX FIFO entries, power of 2, >=2
DEFAULT_DIV, 16'd433, reset value of BAUD_DIV; bit period = DIV+1 clocks

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
mem_wen_i  in  4  byte write strobes from execute stage
mem_wdata_i  in  32  store data
mem_waddr_i  in  32  store address
mem_ren_i  in  1  load request from decode stage
mem_raddr_i  in  32  load address
mem_rdata_o  out  32  registered load data, valid the cycle after mem_ren_i
uart_tx_o  out  1  serial output, idle high
tx_empty_o  out  1  level: FIFO empty and FSM in IDLE

Behaviour:
Reset (async, rst=1):
- FIFO empty; FSM IDLE; BAUD_DIV=DEFAULT_DIV; overflow=0.
- mem_rdata_o=0; uart_tx_o=1; tx_empty_o=1.

Register map (offset = addr[3:2]):
- 0 TXDATA, W:
  - wen[0]=1 pushes wdata[7:0].
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - wen[0]=0: no push.
  - Reads return 0.
- 1 STATUS, R:
  - [0] busy (FSM != IDLE or FIFO non-empty); [1] full; [2] empty; [3] overflow.
  - [15:8] FIFO count; all other bits 0.
  - Write with wen[0]=1 and wdata[3]=1 clears overflow (W1C).
  - If an overflow occurs in the same cycle as the clear, set wins.
- 2 BAUD_DIV, R/W:
  - [15:0], written per byte lane (wen[0], wen[1]); upper bits read 0.
  - A change takes effect at the next bit boundary; the current bit completes with the old count.
- 3 reserved: reads 0, writes ignored.

Reads:
- mem_rdata_o is updated every cycle.
- If mem_ren_i and the address hits the window: mem_rdata_o <= register value; otherwise mem_rdata_o <= 0.
- A read and a write to the same register in the same cycle return the pre-write value.

FSM: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE: uart_tx_o=1. When the FIFO is non-empty: pop into the shift register, load the baud counter with DIV, go to START.
- Each state holds its bit for DIV+1 clocks. The counter counts down; a bit ends on the cycle the counter is 0.
- START: drive 0.
- DATA: drive shift[0] (LSB first); bit index 0..7. After bit 7, go to STOP.
- STOP: drive 1 for one bit period. At its end:
  - FIFO non-empty: pop and go directly to START (back-to-back, no idle gap).
  - Otherwise: go to IDLE.
- DIV=0 is legal: one clock per bit.
- uart_tx_o is registered; no glitches.
- Reset mid-frame aborts the frame; the line returns high immediately.

FIFO:
- Circular buffer with wrap-around pointers and a count of width log2(FIFO_DEPTH)+1.
- Simultaneous push and pop when full: both occur, count unchanged.
- Simultaneous push and pop when empty: not possible, since pop requires a non-empty FIFO.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP and drives the even-parity bit (XOR of the 8 data bits). Frame = 11 bit periods.
- Undefined: no PARITY state exists. Frame = 10 bit periods.
- Register map is unchanged in both cases.

Decomposition:
Shared header uart_defines.v holds:
- register offsets (TXDATA=2'd0, STATUS=2'd1, BAUD_DIV=2'd2)
- STATUS bit positions
- FSM state encodings
- default DIV constant.

Sub-module tx_fifo (parameterised sync FIFO):
- ports: push, pop, din[7:0], dout, full, empty, count.
- Top level holds the decode, register, and FSM logic.

Test Plan:
1. Reset, then write BAUD_DIV=3 and TXDATA=0x55 -> line low for 4 clks (start), then bits 1,0,1,0,1,0,1,0 at 4 clks each, high 4 clks; frame 40 clks; tx_empty_o returns to 1.
2. Push 0xA5 and 0x3C back-to-back, DIV=0 -> 20 consecutive bit clocks with no idle gap between the stop bit and the second start bit.
3. Push 10 bytes while idle with DIV=3 (FIFO_DEPTH=8) -> first byte pops next cycle; 9 accepted, 10th dropped; STATUS read gives overflow=1, full=1, count=8; write STATUS 0x8 -> overflow=0.
4. Read STATUS at BASE+4 -> mem_rdata_o valid exactly 1 cycle after mem_ren_i; read of 0x2000_0000 -> 0; read of offset 0xC -> 0.
5. Change BAUD_DIV 3->7 mid-DATA -> current bit stays 4 clks, subsequent bits 8 clks.
6. Assert rst mid-DATA -> uart_tx_o=1 and mem_rdata_o=0 asynchronously; FIFO empty; with UART_TX_PARITY_EN, 0x07 sends parity bit 1 before stop.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets (addr[3:2]) of the 16-byte window
//   - STATUS register bit positions
//   - transmit FSM state encoding
//   - reset value of the baud divisor
//   - even-parity helper, used when UART_TX_PARITY_EN is defined
// No ports; imported with "import uart_tx_mmio_pkg::*;".
package uart_tx_mmio_pkg;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  // Bit period is DIV+1 clocks.
  localparam logic [15:0] UART_DEFAULT_DIV = 16'd433;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_tx_fifo.sv
// uart_tx_mmio_tx_fifo
// Synchronous byte FIFO (circular buffer) feeding the UART transmit FSM.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   push     : write request; accepted when not full, or when a pop
//              happens in the same cycle
//   pop      : read request; ignored when empty
//   din      : byte to push
//   dout     : byte at the head of the FIFO (valid when not empty)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of stored bytes, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two and at least 2, so the pointers wrap
// naturally.
module uart_tx_mmio_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped UART transmitter on the data-side bus. Stores to TXDATA
// queue bytes in a FIFO; a bit-serial FSM sends them LSB first framed by
// a start bit (0) and a stop bit (1). Loads return STATUS / BAUD_DIV one
// cycle after the request, and 0 outside the window so read data can be
// OR-combined with RAM.
// Optional feature macro: UART_TX_PARITY_EN -- inserts an even-parity bit
// between the data bits and the stop bit (11-bit frame instead of 10).
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   mem_wen_i    : byte write strobes (execute stage)
//   mem_wdata_i  : store data
//   mem_waddr_i  : store address
//   mem_ren_i    : load request (decode stage)
//   mem_raddr_i  : load address
//   mem_rdata_o  : registered load data, valid the cycle after mem_ren_i
//   uart_tx_o    : registered serial output, idle high
//   tx_empty_o   : FIFO empty and FSM idle
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_wen_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] mem_waddr_i,
  input  logic        mem_ren_i,
  input  logic [31:0] mem_raddr_i,
  output logic [31:0] mem_rdata_o,
  output logic        uart_tx_o,
  output logic        tx_empty_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state;
  logic [15:0]   baud_cnt;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          tx_q;
  logic [15:0]   div;
  logic          overflow;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  logic          wr_hit;
  logic [1:0]    wr_off;
  logic          rd_hit;
  logic [1:0]    rd_off;
  logic          txdata_wr;
  logic          ovf_set;
  logic          ovf_clr;
  logic [31:0]   status_word;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  assign wr_hit    = (mem_waddr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_off    = mem_waddr_i[3:2];
  assign rd_hit    = (mem_raddr_i[31:4] == BASE_ADDR[31:4]);
  assign rd_off    = mem_raddr_i[3:2];

  assign txdata_wr = wr_hit && (wr_off == REG_TXDATA) && mem_wen_i[0];
  assign ovf_set   = txdata_wr && fifo_full && !fifo_pop;
  assign ovf_clr   = wr_hit && (wr_off == REG_STATUS) && mem_wen_i[0] && mem_wdata_i[3];

  assign unused_bits = ^{mem_wdata_i[31:16], mem_wen_i[3:2],
                         mem_waddr_i[1:0], mem_raddr_i[1:0]};

  uart_tx_mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (txdata_wr),
    .pop   (fifo_pop),
    .din   (mem_wdata_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A new frame starts either from IDLE or right at the end of a stop bit,
  // which gives back-to-back frames with no idle gap.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      case (state)
        ST_IDLE: fifo_pop = 1'b1;
        ST_STOP: fifo_pop = (baud_cnt == '0);
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  // Transmit FSM. The counter is reloaded from div only at bit boundaries,
  // so a divisor change never stretches or shortens the bit in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (fifo_pop) begin
      state    <= ST_START;
      shift    <= fifo_dout;
      baud_cnt <= div;
      bit_idx  <= '0;
      tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= even_parity(fifo_dout);
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q <= 1'b1;
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            state    <= ST_DATA;
            baud_cnt <= div;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx_q  <= parity_bit;
`else
              state <= ST_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_cnt == '0) begin
            state    <= ST_STOP;
            baud_cnt <= div;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_cnt == '0) begin
            state <= ST_IDLE;
            tx_q  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  // Divisor and sticky overflow. A drop in the same cycle as a W1C clear
  // keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_hit && (wr_off == REG_BAUD_DIV)) begin
        if (mem_wen_i[0]) div[7:0]  <= mem_wdata_i[7:0];
        if (mem_wen_i[1]) div[15:8] <= mem_wdata_i[15:8];
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    status_word                             = '0;
    status_word[STAT_BUSY]                  = (state != ST_IDLE) || !fifo_empty;
    status_word[STAT_FULL]                  = fifo_full;
    status_word[STAT_EMPTY]                 = fifo_empty;
    status_word[STAT_OVERFLOW]              = overflow;
    status_word[STAT_COUNT_LSB +: 8]        = 8'(fifo_count);
  end

  // Read data comes from the current registers, so a same-cycle write is
  // not visible until the following read.
  always_comb begin
    rdata_next = '0;
    if (mem_ren_i && rd_hit) begin
      case (rd_off)
        REG_STATUS:   rdata_next = status_word;
        REG_BAUD_DIV: rdata_next = {16'h0000, div};
        default:      rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata_o <= '0;
    end else begin
      mem_rdata_o <= rdata_next;
    end
  end

  assign uart_tx_o  = tx_q;
  assign tx_empty_o = fifo_empty && (state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio
// Self-checking bench for uart_tx_mmio. A frame-level model (queue of
// pending bytes, list of frame bits, clocks left in the current bit) runs
// alongside the DUT and is compared on every falling edge; directed
// sequences also pin waveforms and register values to literal constants.
// Honours UART_TX_PARITY_EN for the expected frame length.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          DEPTH   = 8;
  localparam logic [15:0] DIV_DEF = 16'd433;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic [31:0] waddr;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        line;
  logic        empty;

  int testCount = 0;
  int failCount = 0;
  int cycle     = 0;
  bit checkOn   = 0;

  // Behavioural model state
  logic [7:0]  q[$];
  bit          mActive;
  logic [10:0] mBits;
  int          mK;
  int          mR;
  logic [15:0] mDiv;
  logic        mOvf;
  logic [31:0] mRdata;

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (DIV_DEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_wen_i   (wen),
    .mem_wdata_i (wdata),
    .mem_waddr_i (waddr),
    .mem_ren_i   (ren),
    .mem_raddr_i (raddr),
    .mem_rdata_o (rdata),
    .uart_tx_o   (line),
    .tx_empty_o  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [10:0] frameOf(input logic [7:0] b);
    logic [10:0] f;
    f      = '0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  // One clock of the model, using the bus inputs present at this edge.
  task automatic modelStep();
    int          sz;
    bit          popped;
    bit          ovfSet;
    logic [31:0] st;
    logic [31:0] rd;
    sz     = q.size();
    popped = 0;
    ovfSet = 0;
    st        = '0;
    st[15:8]  = 8'(sz);
    st[3]     = mOvf;
    st[2]     = (sz == 0);
    st[1]     = (sz == DEPTH);
    st[0]     = mActive || (sz > 0);
    rd = '0;
    if (ren && raddr[31:4] == BASE[31:4]) begin
      if (raddr[3:2] == 2'd1) rd = st;
      else if (raddr[3:2] == 2'd2) rd = {16'h0000, mDiv};
    end
    if (mActive) begin
      mR--;
      if (mR == 0) begin
        mK++;
        if (mK == NB) mActive = 0;
        else mR = int'(mDiv) + 1;
      end
    end
    if (!mActive && sz > 0) begin
      mBits   = frameOf(q.pop_front());
      mK      = 0;
      mR      = int'(mDiv) + 1;
      mActive = 1;
      popped  = 1;
    end
    if (waddr[31:4] == BASE[31:4]) begin
      if (waddr[3:2] == 2'd0 && wen[0]) begin
        if (sz < DEPTH || popped) q.push_back(wdata[7:0]);
        else ovfSet = 1;
      end
      if (waddr[3:2] == 2'd1 && wen[0] && wdata[3]) mOvf = 1'b0;
      if (waddr[3:2] == 2'd2) begin
        if (wen[0]) mDiv[7:0]  = wdata[7:0];
        if (wen[1]) mDiv[15:8] = wdata[15:8];
      end
    end
    if (ovfSet) mOvf = 1'b1;
    mRdata = rd;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mActive = 0;
      mBits   = '1;
      mK      = 0;
      mR      = 0;
      mDiv    = DIV_DEF;
      mOvf    = 1'b0;
      mRdata  = '0;
    end else begin
      modelStep();
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (checkOn && !rst) begin
      check("line",  {63'h0, line},  {63'h0, (mActive ? mBits[mK] : 1'b1)});
      check("empty", {63'h0, empty}, {63'h0, (q.size() == 0 && !mActive)});
      check("rdata", {32'h0, rdata}, {32'h0, mRdata});
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    waddr = a;
    wdata = d;
    wen   = w;
    @(negedge clk);
    wen   = 4'h0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] r);
    @(negedge clk);
    ren   = 1'b1;
    raddr = a;
    @(negedge clk);
    ren   = 1'b0;
    r     = rdata;
  endtask

  task automatic waitIdle(input int bound);
    for (int i = 0; i < bound && !empty; i++) @(negedge clk);
    check("idle_wait", {63'h0, empty}, 64'h1);
  endtask

  task automatic checkOutput(input string name, input int n, input logic [63:0] exp);
    logic [63:0] cap;
    cap    = '0;
    cap[0] = line;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      cap[i] = line;
    end
    check(name, cap, exp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [63:0] cap;
    rst   = 1'b1;
    wen   = 4'h0;
    wdata = '0;
    waddr = '0;
    ren   = 1'b0;
    raddr = '0;
    repeat (3) @(negedge clk);
    check("reset_line",  {63'h0, line},  64'h1);
    check("reset_empty", {63'h0, empty}, 64'h1);
    check("reset_rdata", {32'h0, rdata}, 64'h0);
    #1 rst = 1'b0;
    checkOn = 1;

    busRead(BASE + 32'h4, r);
    check("reset_status", {32'h0, r}, 64'h4);
    busRead(BASE + 32'h8, r);
    check("reset_baud", {32'h0, r}, 64'h1B1);

    // 0x55 at DIV=3
    applyStimulus(BASE + 32'h8, 32'd3, 4'b0011);
    applyStimulus(BASE, 32'h55, 4'b0001);
    @(negedge clk);
`ifdef UART_TX_PARITY_EN
    checkOutput("frame_55", 44, 64'hF00F0F0F0F0);
`else
    checkOutput("frame_55", 40, 64'hF0F0F0F0F0);
`endif
    @(negedge clk);
    check("empty_after_55", {63'h0, empty}, 64'h1);

    // Back-to-back 0xA5, 0x3C at DIV=0
    applyStimulus(BASE + 32'h8, 32'd0, 4'b0011);
    @(negedge clk);
    waddr = BASE; wdata = 32'hA5; wen = 4'b0001;
    @(negedge clk);
    wdata = 32'h3C;
    @(negedge clk);
    wen = 4'h0;
`ifdef UART_TX_PARITY_EN
    checkOutput("b2b_frames", 22, 64'h23C54A);
`else
    checkOutput("b2b_frames", 20, 64'h9E34A);
`endif
    waitIdle(100);

    // Ten pushes into an 8-deep FIFO at DIV=3
    applyStimulus(BASE + 32'h8, 32'd3, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      waddr = BASE; wdata = 32'(i + 1); wen = 4'b0001;
    end
    @(negedge clk);
    wen = 4'h0;
    busRead(BASE + 32'h4, r);
    check("status_overflow", {32'h0, r}, 64'h80B);
    applyStimulus(BASE + 32'h4, 32'h8, 4'b0001);
    busRead(BASE + 32'h4, r);
    check("status_cleared", {32'h0, r}, 64'h803);
    waitIdle(1000);

    // Read timing and out-of-window reads
    @(negedge clk);
    ren = 1'b1; raddr = BASE + 32'h4;
    check("rd_not_early", {32'h0, rdata}, 64'h0);
    @(negedge clk);
    ren = 1'b0;
    check("rd_latency", {32'h0, rdata}, 64'h4);
    @(negedge clk);
    check("rd_drop", {32'h0, rdata}, 64'h0);
    busRead(32'h2000_0004, r);
    check("rd_outside", {32'h0, r}, 64'h0);
    busRead(BASE + 32'hC, r);
    check("rd_reserved", {32'h0, r}, 64'h0);

    // Divisor change 3 -> 7 in the middle of data bit 0
    applyStimulus(BASE, 32'h55, 4'b0001);
    cap = '0;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      cap[t] = line;
      if (t == 6) begin
        waddr = BASE + 32'h8; wdata = 32'd7; wen = 4'b0001;
      end else if (t == 7) begin
        wen = 4'h0;
      end
    end
    check("baud_change", cap, 64'hFF00F0);
    waitIdle(1000);

    // Reset in the middle of a frame
    applyStimulus(BASE + 32'h8, 32'd3, 4'b0001);
    applyStimulus(BASE, 32'h00, 4'b0001);
    applyStimulus(BASE, 32'h11, 4'b0001);
    repeat (8) @(negedge clk);
    busRead(BASE + 32'h4, r);
    check("status_busy", {32'h0, r}, 64'h101);
    check("line_mid_data", {63'h0, line}, 64'h0);
    #2 rst = 1'b1;
    #1;
    check("async_line",  {63'h0, line},  64'h1);
    check("async_rdata", {32'h0, rdata}, 64'h0);
    check("async_empty", {63'h0, empty}, 64'h1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    busRead(BASE + 32'h4, r);
    check("status_after_rst", {32'h0, r}, 64'h4);
    busRead(BASE + 32'h8, r);
    check("baud_after_rst", {32'h0, r}, 64'h1B1);

    // 0x07 at DIV=0 (parity bit 1 when enabled)
    applyStimulus(BASE + 32'h8, 32'd0, 4'b0011);
    applyStimulus(BASE, 32'h07, 4'b0001);
    @(negedge clk);
`ifdef UART_TX_PARITY_EN
    checkOutput("frame_07", 11, 64'h60E);
`else
    checkOutput("frame_07", 10, 64'h20E);
`endif
    waitIdle(100);

    // Randomised traffic checked by the model
    for (int n = 0; n < 4000; n++) begin
      int          sel;
      logic [31:0] a;
      @(negedge clk);
      wen = 4'h0;
      sel = $urandom_range(0, 99);
      a   = BASE | 32'($urandom_range(0, 3));
      if (sel < 30) begin
        a[3:2] = 2'd0;
        wdata  = $urandom;
        wen    = 4'($urandom);
        wen[0] = ($urandom_range(0, 7) != 0);
      end else if (sel < 36) begin
        a[3:2] = 2'd1;
        wdata  = $urandom;
        wen    = 4'($urandom);
      end else if (sel < 40) begin
        a[3:2] = 2'($urandom_range(2, 3));
        wdata  = {16'($urandom), 8'h00, 8'($urandom_range(0, 3))};
        wen    = 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) a = a ^ (32'h10 << $urandom_range(0, 27));
      waddr = a;
      ren   = 1'($urandom_range(0, 1));
      raddr = BASE | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) raddr = raddr ^ (32'h10 << $urandom_range(0, 27));
    end
    @(negedge clk);
    wen = 4'h0;
    ren = 1'b0;
    waitIdle(2000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
